// File: rtl/ppu_vram_arb.sv
// ppu_vram_arb: shares the single PPU VRAM bus between background fetch,
// sprite fetch and register-interface (0x2007) accesses. Background always
// wins. Sprite is next, unless an RI access has waited too long. RI accesses
// sit in a one-entry slot until they get a free bus cycle.
module ppu_vram_arb #(
    parameter int RI_MAX_WAIT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        bg_req_in,
    input  logic [13:0] bg_a_in,
    input  logic        spr_req_in,
    input  logic [13:0] spr_a_in,
    input  logic        ri_req_in,
    input  logic        ri_wr_in,
    input  logic [13:0] ri_a_in,
    input  logic [7:0]  ri_d_in,
    input  logic [7:0]  vram_d_in,
    output logic [13:0] vram_a_out,
    output logic [7:0]  vram_d_out,
    output logic        vram_wr_out,
    output logic        bg_gnt_out,
    output logic        spr_gnt_out,
    output logic        ri_busy_out,
    output logic [7:0]  ri_d_out,
    output logic        ri_done_out,
    output logic        ri_inc_addr_out,
    output logic        ri_drop_out
);

    // The wait counter is 8 bits wide, enough for the largest legal limit.
    localparam logic [7:0] WAIT_LIMIT = 8'(RI_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        pend_wr;
    logic [13:0] pend_a;
    logic [7:0]  pend_d;
    logic [7:0]  wait_cnt;

    logic        ri_accept;
    logic        ri_win;
    logic        wait_expired;

    // State register; reset throws away any pending access.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, winner selection and the combinational bus mux.
    // A starved RI outranks sprites, but it never outranks background.
    always_comb begin
        state_nxt       = state;
        ri_accept       = 1'b0;
        ri_win          = 1'b0;
        wait_expired    = 1'b0;
        bg_gnt_out      = bg_req_in;
        spr_gnt_out     = 1'b0;
        vram_a_out      = pend_a;
        vram_d_out      = pend_d;
        vram_wr_out     = 1'b0;
        ri_busy_out     = (state != IDLE);
        ri_done_out     = 1'b0;
        ri_inc_addr_out = 1'b0;

        if (state == PEND) begin
            wait_expired = (wait_cnt >= WAIT_LIMIT);
        end

        spr_gnt_out = spr_req_in & ~bg_req_in & ~wait_expired;

        case (state)
            IDLE: begin
                if (ri_req_in) begin
                    ri_accept = 1'b1;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (!bg_req_in && !spr_gnt_out) begin
                    ri_win    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ri_done_out     = ~rst_in;
                ri_inc_addr_out = ~rst_in;
                state_nxt       = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (bg_req_in) begin
            vram_a_out = bg_a_in;
        end else if (spr_gnt_out) begin
            vram_a_out = spr_a_in;
        end

        vram_wr_out = ri_win & pend_wr & ~rst_in;
    end

    // Pending slot, wait counter, read data capture and the drop pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_wr     <= 1'b0;
            pend_a      <= 14'h0000;
            pend_d      <= 8'h00;
            wait_cnt    <= 8'h00;
            ri_d_out    <= 8'h00;
            ri_drop_out <= 1'b0;
        end else begin
            ri_drop_out <= ri_req_in & (state != IDLE);

            if (ri_accept) begin
                pend_wr  <= ri_wr_in;
                pend_a   <= ri_a_in;
                pend_d   <= ri_d_in;
                wait_cnt <= 8'h00;
            end else if ((state == PEND) && !ri_win && (wait_cnt != WAIT_LIMIT)) begin
                wait_cnt <= wait_cnt + 8'h01;
            end

            if (ri_win && !pend_wr) begin
                ri_d_out <= vram_d_in;
            end
        end
    end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// tb_ppu_vram_arb: directed scenarios followed by random traffic, with every
// cycle compared against a transaction-level model of the RI slot.
module tb_ppu_vram_arb;

    localparam int MAXW = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        bg_req_in;
    logic [13:0] bg_a_in;
    logic        spr_req_in;
    logic [13:0] spr_a_in;
    logic        ri_req_in;
    logic        ri_wr_in;
    logic [13:0] ri_a_in;
    logic [7:0]  ri_d_in;
    logic [7:0]  vram_d_in;
    logic [13:0] vram_a_out;
    logic [7:0]  vram_d_out;
    logic        vram_wr_out;
    logic        bg_gnt_out;
    logic        spr_gnt_out;
    logic        ri_busy_out;
    logic [7:0]  ri_d_out;
    logic        ri_done_out;
    logic        ri_inc_addr_out;
    logic        ri_drop_out;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model: an outstanding RI transaction, how long it has been refused,
    // and the pulses it owes the outside world.
    typedef struct packed {
        logic        wr;
        logic [13:0] a;
        logic [7:0]  d;
    } ri_txn_t;

    ri_txn_t  m_req;
    bit       m_has_req;
    int       m_denied;
    bit       m_done_due;
    bit       m_drop_due;
    logic [7:0] m_rdata;
    int       accepted_writes = 0;
    int       dut_writes = 0;

    ppu_vram_arb #(.RI_MAX_WAIT(MAXW)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bg_req_in(bg_req_in),
        .bg_a_in(bg_a_in),
        .spr_req_in(spr_req_in),
        .spr_a_in(spr_a_in),
        .ri_req_in(ri_req_in),
        .ri_wr_in(ri_wr_in),
        .ri_a_in(ri_a_in),
        .ri_d_in(ri_d_in),
        .vram_d_in(vram_d_in),
        .vram_a_out(vram_a_out),
        .vram_d_out(vram_d_out),
        .vram_wr_out(vram_wr_out),
        .bg_gnt_out(bg_gnt_out),
        .spr_gnt_out(spr_gnt_out),
        .ri_busy_out(ri_busy_out),
        .ri_d_out(ri_d_out),
        .ri_done_out(ri_done_out),
        .ri_inc_addr_out(ri_inc_addr_out),
        .ri_drop_out(ri_drop_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The RI transaction gets the bus only when nobody with higher rank wants it.
    function automatic bit riTurn();
        return m_has_req && !bg_req_in && !(spr_req_in && (m_denied < MAXW));
    endfunction

    task automatic checkOutput();
        bit          starved;
        bit          exp_spr;
        bit          exp_wr;
        logic [13:0] exp_a;
        if (vram_wr_out === 1'b1) dut_writes++;
        if (!check_en) return;
        starved = m_has_req && (m_denied >= MAXW);
        exp_spr = spr_req_in && !bg_req_in && !starved;
        exp_wr  = riTurn() && m_req.wr && !rst_in;
        exp_a   = bg_req_in ? bg_a_in : (exp_spr ? spr_a_in : m_req.a);
        checkVal("bg_gnt", 16'(bg_gnt_out), 16'(bg_req_in));
        checkVal("spr_gnt", 16'(spr_gnt_out), 16'(exp_spr));
        checkVal("vram_a", 16'(vram_a_out), 16'(exp_a));
        checkVal("vram_wr", 16'(vram_wr_out), 16'(exp_wr));
        if (exp_wr) checkVal("vram_d", 16'(vram_d_out), 16'(m_req.d));
        checkVal("ri_busy", 16'(ri_busy_out), 16'(m_has_req || m_done_due));
        checkVal("ri_done", 16'(ri_done_out), 16'(m_done_due && !rst_in));
        checkVal("ri_inc", 16'(ri_inc_addr_out), 16'(m_done_due && !rst_in));
        checkVal("ri_drop", 16'(ri_drop_out), 16'(m_drop_due));
        checkVal("ri_d_out", 16'(ri_d_out), 16'(m_rdata));
    endtask

    // Advances the model across one clock edge using the inputs of this cycle.
    task automatic modelAdvance();
        bit busy;
        bit turn;
        busy = m_has_req || m_done_due;
        turn = riTurn();
        if (rst_in) begin
            if (m_has_req && m_req.wr) accepted_writes--;
            m_req      = '0;
            m_has_req  = 1'b0;
            m_denied   = 0;
            m_done_due = 1'b0;
            m_drop_due = 1'b0;
            m_rdata    = 8'h00;
            return;
        end
        m_drop_due = ri_req_in && busy;
        if (m_done_due) begin
            m_done_due = 1'b0;
        end else if (m_has_req) begin
            if (turn) begin
                if (!m_req.wr) m_rdata = vram_d_in;
                m_has_req  = 1'b0;
                m_done_due = 1'b1;
            end else begin
                m_denied = (m_denied + 1 > MAXW) ? MAXW : m_denied + 1;
            end
        end else if (ri_req_in) begin
            m_req     = '{wr: ri_wr_in, a: ri_a_in, d: ri_d_in};
            m_has_req = 1'b1;
            m_denied  = 0;
            if (ri_wr_in) accepted_writes++;
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit bg, input logic [13:0] bga,
                                 input bit spr, input logic [13:0] spra,
                                 input bit req, input bit wr, input logic [13:0] a,
                                 input logic [7:0] d, input logic [7:0] vd);
        @(negedge clk_in);
        rst_in     = rst;
        bg_req_in  = bg;
        bg_a_in    = bga;
        spr_req_in = spr;
        spr_a_in   = spra;
        ri_req_in  = req;
        ri_wr_in   = wr;
        ri_a_in    = a;
        ri_d_in    = d;
        vram_d_in  = vd;
        #1;
        checkOutput();
        modelAdvance();
        check_en = 1'b1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 14'h0000, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 8'h00);
    endtask

    initial begin
        m_req = '0; m_has_req = 0; m_denied = 0; m_done_due = 0; m_drop_due = 0; m_rdata = 8'h00;

        $display("[TB] reset");
        applyStimulus(1, 0, 14'h0000, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 8'h00);
        applyStimulus(1, 0, 14'h0000, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 8'h00);
        idleCycle();

        $display("[TB] idle read");
        applyStimulus(0, 0, 14'h0000, 0, 14'h0000, 1, 0, 14'h2345, 8'h00, 8'h00);
        applyStimulus(0, 0, 14'h0000, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 8'hA5);
        idleCycle();
        idleCycle();
        checkVal("idle_read_data", 16'(ri_d_out), 16'h00A5);

        $display("[TB] write deferred by background");
        applyStimulus(0, 0, 14'h0000, 0, 14'h0000, 1, 1, 14'h3F00, 8'h1C, 8'h00);
        for (int i = 1; i <= 4; i++)
            applyStimulus(0, 1, 14'h0100 + 14'(i), 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) idleCycle();

        $display("[TB] starvation guard");
        applyStimulus(0, 0, 14'h0000, 1, 14'h1000, 1, 0, 14'h0ABC, 8'h00, 8'h00);
        for (int i = 1; i <= 7; i++)
            applyStimulus(0, 0, 14'h0000, 1, 14'h1000 + 14'(i), 0, 0, 14'h0000, 8'h00, 8'h5A);
        idleCycle();
        checkVal("starve_read_data", 16'(ri_d_out), 16'h005A);

        $display("[TB] background never pre-empted");
        applyStimulus(0, 0, 14'h0000, 0, 14'h0000, 1, 1, 14'h2001, 8'h77, 8'h00);
        for (int i = 0; i < 40; i++)
            applyStimulus(0, 1, 14'(i), 1, 14'h0333, 0, 0, 14'h0000, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) idleCycle();

        $display("[TB] dropped requests");
        applyStimulus(0, 0, 14'h0000, 0, 14'h0000, 1, 1, 14'h1111, 8'h55, 8'h00);
        applyStimulus(0, 1, 14'h0200, 0, 14'h0000, 1, 0, 14'h2222, 8'hEE, 8'h00);
        applyStimulus(0, 1, 14'h0201, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 8'h00);
        idleCycle();
        applyStimulus(0, 0, 14'h0000, 0, 14'h0000, 1, 0, 14'h3333, 8'h99, 8'h00);
        for (int i = 0; i < 2; i++) idleCycle();

        $display("[TB] reset while pending");
        applyStimulus(0, 0, 14'h0000, 0, 14'h0000, 1, 1, 14'h0444, 8'h44, 8'h00);
        applyStimulus(0, 1, 14'h0300, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 8'h00);
        applyStimulus(1, 1, 14'h0301, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) idleCycle();
        checkVal("post_reset_busy", 16'(ri_busy_out), 16'h0000);
        checkVal("post_reset_rdata", 16'(ri_d_out), 16'h0000);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                          14'($urandom), ($urandom_range(0, 1) == 1), 14'($urandom),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
                          14'($urandom), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 5; i++) idleCycle();
        checkVal("write_count", 16'(dut_writes), 16'(accepted_writes));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_vram_arb.md
Name: ppu_vram_arb

Overview:
- Arbitrates the single PPU VRAM address/data bus between three requesters: background fetch, sprite fetch and register-interface (RI) 0x2007 accesses.
- Background fetches have fixed top priority. Sprite fetches come next. RI accesses are buffered in a one-entry pending slot and serviced in free bus cycles.
- A starvation guard lets a waiting RI access pre-empt sprite fetches.
- On completion of each RI access, the block issues the scroll-counter increment pulse to the background block.

Parameters:
- RI_MAX_WAIT, 16, number of denied pending cycles after which RI outranks sprite requests (range 1..255).

Ports:
- clk_in  in  1  100MHz system clock
- rst_in  in  1  synchronous active-high reset
- bg_req_in  in  1  background fetch wants the bus this cycle
- bg_a_in  in  14  background fetch address
- spr_req_in  in  1  sprite fetch wants the bus this cycle
- spr_a_in  in  14  sprite fetch address
- ri_req_in  in  1  one-cycle RI access request
- ri_wr_in  in  1  1=write, 0=read (sampled with ri_req_in)
- ri_a_in  in  14  RI address (sampled with ri_req_in)
- ri_d_in  in  8  RI write data (sampled with ri_req_in)
- vram_d_in  in  8  VRAM read data, valid combinationally in the cycle the address is driven
- vram_a_out  out  14  VRAM address
- vram_d_out  out  8  VRAM write data
- vram_wr_out  out  1  VRAM write strobe
- bg_gnt_out  out  1  background owns the bus this cycle
- spr_gnt_out  out  1  sprite owns the bus this cycle
- ri_busy_out  out  1  RI slot occupied
- ri_d_out  out  8  RI read data, registered
- ri_done_out  out  1  one-cycle RI completion pulse
- ri_inc_addr_out  out  1  one-cycle pulse to increment scroll counters
- ri_drop_out  out  1  one-cycle pulse: request rejected because the slot was busy

Behaviour:
- FSM states: IDLE, PEND, DONE. ri_busy_out = (state != IDLE).
- IDLE:
  - ri_req_in=1 latches wr, address and data into the pending registers.
  - Clears the wait counter.
  - Transitions to PEND.
- PEND, winner selection each cycle:
  - bg_req_in → background wins.
  - Otherwise, spr_req_in with wait < RI_MAX_WAIT → sprite wins.
  - Otherwise → RI wins.
- PEND, outcome:
  - If RI wins, that cycle is the RI access: vram_a_out = pending address; on a write, vram_wr_out=1 and vram_d_out = pending data; on a read, vram_d_in is captured into ri_d_out at the clock edge. The FSM then goes to DONE.
  - If RI loses, the wait counter increments (saturating at RI_MAX_WAIT) and the FSM stays in PEND.
- DONE: ri_done_out=1 and ri_inc_addr_out=1 for exactly one cycle, then IDLE. ri_d_out stays stable until the next read completes.
- Minimum latency: ri_req_in at cycle N gives access at N+1 and ri_done_out at N+2. Next request accepted from N+3 (IDLE).
- Dropped requests: ri_req_in while ri_busy_out=1 is ignored, pulses ri_drop_out next cycle, and does not disturb the pending slot.
- Grants and address mux (combinational):
  - bg_gnt_out = bg_req_in.
  - spr_gnt_out = spr_req_in & ~bg_req_in & ~(PEND & wait ≥ RI_MAX_WAIT).
  - vram_a_out selects the bg, spr or RI address per the winner.
  - With no requester active, vram_a_out = pending RI address, and vram_wr_out=0.
- Simultaneous bg_req_in and spr_req_in outside PEND: bg granted, spr not granted; the requester must retry.
- Reset outputs: state IDLE, wait 0, pending registers 0, ri_d_out 0x00, ri_done_out/ri_inc_addr_out/ri_drop_out 0. vram_wr_out is forced 0 while rst_in=1.
- Reset mid-operation: a pending access is discarded with no VRAM write and no done or increment pulse.
- Writes: exactly one vram_wr_out cycle per accepted write request.

Test Plan:
- Idle read: no bg/spr requests, ri_req at cycle 0 (rd, addr 0x2345) with vram_d_in=0xA5 at cycle 1 → vram_a_out=0x2345 at cycle 1; ri_done/ri_inc_addr pulse at cycle 2; ri_d_out=0xA5.
- Write deferred by bg: bg_req_in high cycles 1–4, ri write 0x3F00←0x1C requested at cycle 0 → vram_wr_out exactly once, at cycle 5, with a=0x3F00, d=0x1C; done at cycle 6.
- Starvation: RI_MAX_WAIT=4, spr_req_in held high, bg idle → RI denied cycles 1–4, RI access at cycle 5 (spr_gnt_out=0 there), done at cycle 6.
- Bg never pre-empted: bg_req_in held high 40 cycles with RI pending → no RI access and no done pulse until cycle after bg_req_in drops.
- Drop: second ri_req_in issued while in PEND → ri_drop_out pulse, original address/data/wr completed unchanged.
- Reset mid-PEND: pending write, bg busy, rst_in asserted one cycle → no vram_wr_out, no ri_done_out; state IDLE; ri_d_out=0x00.
